// File: rtl/cache_arbiter_pkg.sv
// Shared types for the LC-3b cache arbiter: line/word types and arbiter state encoding.
package cache_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: D over I).
//
// state    | meaning
// ARB_IDLE | no transaction; sample requests and latch the winner
// ARB_I    | serving I-cache line read
// ARB_D    | serving D-cache line read or write-back
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              wflag;
    logic              d_req;
    logic              grant_d, grant_i;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;   // 0 = I served last, 1 = D served last

    assign grant_d = d_req && (!i_read || !last_grant);
    assign grant_i = i_read && (!d_req || last_grant);
`else
    assign grant_d = d_req;
    assign grant_i = i_read && !d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wflag   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE) begin
                if (state_nxt == ARB_D) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wflag   <= d_write;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant <= 1'b1;
`endif
                end else if (state_nxt == ARB_I) begin
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                    wflag   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant <= 1'b0;
`endif
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (grant_d)      state_nxt = ARB_D;
                else if (grant_i) state_nxt = ARB_I;
            end
            ARB_I, ARB_D: begin
                if (pmem_resp) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // A requester that withdrew mid-transaction gets no resp pulse.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;
        if (state == ARB_I || state == ARB_D) begin
            pmem_read  = !wflag;
            pmem_write = wflag;
        end
        if (state == ARB_I && pmem_resp && i_read) begin
            i_resp  = 1'b1;
            i_rdata = pmem_rdata;
        end
        if (state == ARB_D && pmem_resp && d_req) begin
            d_resp  = 1'b1;
            d_rdata = pmem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed, table-driven bench for cache_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_cache_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [15:0]  i_addr, d_addr;
    logic [127:0] d_wdata, pmem_rdata;
    logic [127:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_addr;

    int n_checks = 0;
    int n_pass   = 0;
    logic bench_last = 1'b1;   // which side the arbiter served last (1 = D)

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    typedef struct {
        logic         side_d;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           delay;
        logic         exp_read;
        logic         exp_write;
    } vec_t;

    vec_t vecs[5];

    // Runs one single-requester transaction; entered just after a clock edge with the arbiter idle.
    task automatic run_vec(input vec_t v);
        pmem_rdata = v.rdata;
        if (v.side_d) begin
            d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_read = 1'b1; i_addr = v.addr;
        end
        @(posedge clk); #1;
        // Inputs wander after the grant; the latched copies must not.
        d_addr = ~v.addr; i_addr = ~v.addr; d_wdata = ~v.wdata;
        for (int k = 0; k <= v.delay; k++) begin
            if (k == v.delay) pmem_resp = 1'b1;
            @(negedge clk);
            chk("vec_pmem_read", pmem_read, v.exp_read);
            chk("vec_pmem_write", pmem_write, v.exp_write);
            chk("vec_pmem_addr", pmem_addr, v.addr);
            if (v.exp_write) chk("vec_pmem_wdata", pmem_wdata, v.wdata);
            if (k < v.delay) begin
                chk("vec_early_resp", {i_resp, d_resp}, 2'b00);
                chk("vec_early_rdata", i_rdata | d_rdata, '0);
                @(posedge clk); #1;
            end else begin
                chk("vec_i_resp", i_resp, !v.side_d);
                chk("vec_d_resp", d_resp, v.side_d);
                chk("vec_rdata", v.side_d ? d_rdata : i_rdata, v.rdata);
                chk("vec_other_rdata", v.side_d ? i_rdata : d_rdata, '0);
            end
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        bench_last = v.side_d;
        @(negedge clk);
        chk("vec_idle_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("vec_idle_resp", {i_resp, d_resp}, 2'b00);
    endtask

    // Completes a granted read; entered just after the grant edge.
    task automatic serve(input logic exp_d, input logic [15:0] exp_addr, input bit drop);
        logic [127:0] line;
        line = {8{16'hC3C3}} ^ {112'd0, exp_addr};
        @(negedge clk);
        chk("serve_addr", pmem_addr, exp_addr);
        chk("serve_read", pmem_read, 1'b1);
        pmem_rdata = line; pmem_resp = 1'b1;
        #1;
        chk("serve_d_resp", d_resp, exp_d);
        chk("serve_i_resp", i_resp, !exp_d);
        chk("serve_rdata", exp_d ? d_rdata : i_rdata, line);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        if (drop) begin
            if (exp_d) d_read = 1'b0;
            else       i_read = 1'b0;
        end
        bench_last = exp_d;
        @(negedge clk);
        chk("serve_gap_idle", pmem_read, 1'b0);
        @(posedge clk); #1;
    endtask

    function automatic logic pick_both();
        return RR ? !bench_last : 1'b1;
    endfunction

    initial begin
        logic w;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, '0, {16{8'hA5}}, 3, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h4440, '0, {8{16'h1234}}, 1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h2000, {8{16'hDEAD}}, {8{16'h5A5A}}, 2, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h3010, {4{32'hCAFEF00D}}, {4{32'h0BADBEEF}}, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h00F0, '0, {4{32'h87654321}}, 0, 1'b1, 1'b0};

        rst_n = 1'b0; i_read = 1'b1; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b1;
        i_addr = 16'h1111; d_addr = 16'h2222; d_wdata = '1; pmem_rdata = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_addr", pmem_addr, 16'h0);
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_rdata", i_rdata | d_rdata, '0);
        i_read = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[n]) run_vec(vecs[n]);

        // Simultaneous requests: D first by priority, or the side not served last under round robin.
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 16'h0040; d_read = 1'b1; d_addr = 16'h8000;
        @(posedge clk); #1;
        w = pick_both();
        serve(w, w ? 16'h8000 : 16'h0040, 1'b1);
        serve(!w, w ? 16'h0040 : 16'h8000, 1'b1);

        // Requester withdraws mid-transaction: access completes, no resp.
        i_read = 1'b1; i_addr = 16'h0abc; pmem_rdata = {8{16'h7777}};
        @(posedge clk); #1;
        i_read = 1'b0;
        @(negedge clk);
        chk("drop_read_held", pmem_read, 1'b1);
        pmem_resp = 1'b1; #1;
        chk("drop_no_resp", {i_resp, d_resp}, 2'b00);
        chk("drop_rdata_zero", i_rdata, '0);
        @(posedge clk); #1;
        pmem_resp = 1'b0; bench_last = 1'b0;
        @(negedge clk);
        chk("drop_idle", pmem_read, 1'b0);

        // Reset while D transaction is in flight.
        @(posedge clk); #1;
        d_read = 1'b1; d_addr = 16'h6600;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_active", pmem_read, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        d_read = 1'b0; pmem_resp = 1'b1; bench_last = 1'b1;
        @(negedge clk);
        chk("rstmid_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rstmid_addr", pmem_addr, 16'h0);
        chk("rstmid_no_resp", d_resp, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("rstmid_stays_idle", {pmem_read, d_resp}, 2'b00);
        @(posedge clk); #1;

        // Both held continuously: fixed priority starves I; round robin alternates.
        i_read = 1'b1; i_addr = 16'h0100; d_read = 1'b1; d_addr = 16'h0200;
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) begin
            w = pick_both();
            serve(w, w ? 16'h0200 : 16'h0100, n == 3);
        end
        serve(!w, w ? 16'h0100 : 16'h0200, 1'b1);
        @(negedge clk);
        chk("end_idle", {pmem_read, pmem_write}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
